mips_fetch_queue: RTL
=====================

Name: mips_fetch_queue

Overview:
- Instruction prefetch unit directly upstream of the decode stage of the MIPS32 pipeline.
- Issues sequential word-addressed reads to instruction memory and buffers the returned {npc, instr} pairs in a small FIFO.
- Presents those pairs to decode over a valid/ready handshake.
- Handles taken-branch redirects by flushing the queue, and stops fetching once an HLT opcode has been fetched.

Parameters:
- DEPTH, 4, queue entries; power of two, >= 2.
- AW, 5, instruction address width in words (32-word memory).
- RESET_PC, 0, first fetch address after reset.

Ports:
- clk1  in  1  single clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- imem_req  out  1  read request to instruction memory; always accepted.
- imem_addr  out  AW  word address of the request.
- imem_rdata  in  32  read data; valid exactly one cycle after imem_req.
- id_valid  out  1  queue head is valid.
- id_ready  in  1  decode accepts the head this cycle.
- id_instr  out  32  head instruction.
- id_npc  out  AW  head instruction address + 1.
- redirect_valid  in  1  taken branch; flush and refetch.
- redirect_pc  in  AW  branch target word address.
- halted  out  1  HLT has been enqueued; fetching stopped.
- occupancy  out  $clog2(DEPTH)+1  current queue count.

Behaviour:
- Reset (asynchronous, any time):
  - pc = RESET_PC; queue empty; in-flight flag = 0.
  - imem_req = 0, id_valid = 0, halted = 0, occupancy = 0.
  - Any in-flight response is discarded.
- Issue rule:
  - imem_req = !rst && !halted && !redirect_valid && (occupancy + inflight) < DEPTH.
  - imem_addr = pc.
  - On issue: pc <= pc + 1, modulo 2^AW; wraps from 2^AW-1 to 0.
  - Record the issued address in a register for the response.
- Response (cycle after issue):
  - Enqueue {req_addr + 1, imem_rdata}.
  - Drop the response if redirect_valid is asserted this cycle, if a redirect occurred in the issue cycle, or if halted = 1.
- Credit scheme: occupancy + inflight never exceeds DEPTH, so an enqueue never happens into a full queue, whether or not a dequeue occurs in the same cycle.
- Dequeue:
  - Occurs when id_valid && id_ready.
  - id_valid = (occupancy != 0) && !redirect_valid.
  - id_instr and id_npc are driven from the head entry (registered storage, no combinational path from imem_rdata).
- Simultaneous enqueue and dequeue: occupancy unchanged; works at full and at empty+1.
- Latency:
  - Issue at edge T; data returns during cycle T+1; entry is visible at id_valid in cycle T+2.
  - With id_ready held high, throughput is one instruction per cycle after a 2-cycle fill.
- HLT detection:
  - When an enqueued instr[31:26] == 6'b111111, halted <= 1 at that edge.
  - Issue stops from the next cycle.
  - A response arriving after halted = 1 is dropped.
  - Queue contents still drain to decode.
- Redirect, single-cycle pulse, highest priority:
  - In the redirect cycle: flush the queue (occupancy <= 0), cancel the in-flight read, pc <= redirect_pc, halted <= 0.
  - No dequeue and no issue happen in that cycle.
  - Issue resumes in the next cycle from redirect_pc.
- Redirect on back-to-back cycles: the last one wins.
- Redirect while halted: clears halted and resumes fetching.
- Reset mid-operation: all of the above state returns to reset values immediately; no output glitches beyond the asynchronous clear.

Decomposition:
- Shared package mips_pkg:
  - Opcode constants (ADD..BEQZ, HLT = 6'b111111).
  - Instruction-type encodings (RR_ALU..HALT).
  - INSTR_W = 32.
- Queue storage and pointers go in a sub-module mips_sync_fifo:
  - Parameters WIDTH and DEPTH.
  - Ports: push, pop, flush, count, head.
  - Asynchronous reset.
- Issue/credit/halt/redirect control stays in mips_fetch_queue.

Test Plan:
- Memory words 0..7 = ADD/ADDI/etc. (not HLT), id_ready = 1, reset released → imem_addr sequence 0,1,2,…; first id_valid 2 cycles after the first req with id_instr = mem[0], id_npc = 1; then one instruction per cycle.
- id_ready = 0 for 10 cycles → occupancy saturates at 4, imem_req deasserts, no entry is lost or duplicated; releasing id_ready delivers mem[0..] in order.
- Pulse redirect_valid with redirect_pc = 5 while the queue holds 3 entries and a read is in flight → id_valid = 0 that cycle, occupancy = 0, next imem_addr = 5, first delivered id_instr = mem[5] with id_npc = 6.
- mem[3] = 32'hFC000000 (HLT) → entries 0..3 delivered, halted = 1, no req after addr 4; addr 4 response dropped; a later redirect to 0 clears halted and restarts fetching.
- RESET_PC = 31, AW = 5 → fetch addresses 31, 0, 1; id_npc for addr 31 = 0.
- Assert rst for one cycle with the queue full → occupancy = 0, id_valid = 0, halted = 0; refetch starts at RESET_PC.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: definitions shared by the MIPS32 front-end blocks.
//   - INSTR_W / OPCODE_W : instruction word and opcode field widths
//   - opcode_e           : primary opcodes (ADD..BEQZ, HLT)
//   - instr_type_e       : instruction classes used by decode (RR_ALU..HALT)
//   - is_hlt()           : true when a word carries the HLT opcode
//   - instr_type()       : classifies a word into instr_type_e
package mips_pkg;

    localparam int INSTR_W  = 32;
    localparam int OPCODE_W = 6;

    typedef enum logic [OPCODE_W-1:0] {
        ADD   = 6'b000000,
        SUB   = 6'b000001,
        AND   = 6'b000010,
        OR    = 6'b000011,
        SLT   = 6'b000100,
        MUL   = 6'b000101,
        LW    = 6'b001000,
        SW    = 6'b001001,
        ADDI  = 6'b001010,
        SUBI  = 6'b001011,
        SLTI  = 6'b001100,
        BNEQZ = 6'b001101,
        BEQZ  = 6'b001110,
        HLT   = 6'b111111
    } opcode_e;

    typedef enum logic [2:0] {
        RR_ALU = 3'b000,
        RM_ALU = 3'b001,
        LOAD   = 3'b010,
        STORE  = 3'b011,
        BRANCH = 3'b100,
        HALT   = 3'b101
    } instr_type_e;

    function automatic logic [OPCODE_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
        return instr[INSTR_W-1 -: OPCODE_W];
    endfunction

    function automatic logic is_hlt(input logic [INSTR_W-1:0] instr);
        return opcode_of(instr) == HLT;
    endfunction

    // Unknown opcodes fall into RR_ALU; decode treats them as no-ops.
    function automatic instr_type_e instr_type(input logic [INSTR_W-1:0] instr);
        instr_type_e t;
        t = RR_ALU;
        case (opcode_of(instr))
            ADD, SUB, AND, OR, SLT, MUL: t = RR_ALU;
            ADDI, SUBI, SLTI:            t = RM_ALU;
            LW:                          t = LOAD;
            SW:                          t = STORE;
            BNEQZ, BEQZ:                 t = BRANCH;
            HLT:                         t = HALT;
            default:                     t = RR_ALU;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/mips_sync_fifo.sv
// mips_sync_fifo: small register-based FIFO holding fetched entries.
//   clk1  : clock, all updates on posedge
//   rst   : asynchronous active-high reset (empties the FIFO)
//   push  : write din at the tail (ignored when full without a pop)
//   pop   : remove the head entry (ignored when empty)
//   flush : empty the FIFO this edge; overrides push and pop
//   din   : entry to write
//   count : number of valid entries, 0..DEPTH
//   head  : oldest entry, read straight from the storage registers
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module mips_sync_fifo
    import mips_pkg::*;
#(
    parameter int WIDTH = 37,
    parameter int DEPTH = 4
) (
    input  logic                     clk1,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr_reg;
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW:0]      count_reg;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count_reg != '0);
    // A push into a full FIFO is only legal when the head leaves on the same edge.
    assign do_push = push && ((count_reg != FULL_COUNT) || do_pop);

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + (PW+1)'(1);
                2'b01:   count_reg <= count_reg - (PW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage needs no reset: nothing is visible until count says so.
    always_ff @(posedge clk1) begin
        if (do_push && !flush) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    assign head  = mem[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/mips_fetch_queue.sv
// mips_fetch_queue: instruction prefetch unit feeding the decode stage.
//   clk1           : clock, all updates on posedge
//   rst            : asynchronous active-high reset
//   imem_req       : read request to instruction memory (always accepted)
//   imem_addr      : word address of the request
//   imem_rdata     : read data, valid the cycle after imem_req
//   id_valid       : queue head is valid for decode
//   id_ready       : decode takes the head this cycle
//   id_instr       : head instruction
//   id_npc         : head instruction address + 1
//   redirect_valid : taken branch pulse; flush and refetch
//   redirect_pc    : branch target word address
//   halted         : HLT has been enqueued, fetching stopped
//   occupancy      : current queue count
// Issue is credit based: queued entries plus the one possible read in
// flight never exceed DEPTH, so every response has a free slot waiting.
module mips_fetch_queue
    import mips_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter int          AW       = 5,
    parameter int unsigned RESET_PC = 0
) (
    input  logic                   clk1,
    input  logic                   rst,
    output logic                   imem_req,
    output logic [AW-1:0]          imem_addr,
    input  logic [INSTR_W-1:0]     imem_rdata,
    output logic                   id_valid,
    input  logic                   id_ready,
    output logic [INSTR_W-1:0]     id_instr,
    output logic [AW-1:0]          id_npc,
    input  logic                   redirect_valid,
    input  logic [AW-1:0]          redirect_pc,
    output logic                   halted,
    output logic [$clog2(DEPTH):0] occupancy
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = AW + INSTR_W;
    localparam logic [AW-1:0] RESET_ADDR   = AW'(RESET_PC);
    localparam logic [CW:0]   CREDIT_LIMIT = (CW+1)'(DEPTH);

    logic [AW-1:0] pc_reg;
    logic [AW-1:0] req_addr_reg;
    logic          inflight_reg;
    logic          halted_reg;

    logic          issue;
    logic          do_push;
    logic          do_pop;
    logic [CW-1:0] count;
    logic [CW:0]   credit_used;
    logic [EW-1:0] push_entry;
    logic [EW-1:0] head_entry;

    // Slots already promised: stored entries plus the read still in flight.
    assign credit_used = {1'b0, count} + {{CW{1'b0}}, inflight_reg};

    assign issue     = !rst && !halted_reg && !redirect_valid && (credit_used < CREDIT_LIMIT);
    assign imem_req  = issue;
    assign imem_addr = pc_reg;

    // A redirect in the issue cycle blocks the issue itself, so inflight_reg
    // already excludes that case; here only the current redirect and halt gate it.
    assign do_push    = inflight_reg && !redirect_valid && !halted_reg;
    assign push_entry = {req_addr_reg + AW'(1), imem_rdata};

    assign id_valid = (count != '0) && !redirect_valid;
    assign do_pop   = id_valid && id_ready;

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            pc_reg       <= RESET_ADDR;
            req_addr_reg <= RESET_ADDR;
            inflight_reg <= 1'b0;
            halted_reg   <= 1'b0;
        end else if (redirect_valid) begin
            // Redirect beats everything: the pending response is forgotten and
            // a halt is lifted so fetching restarts from the target.
            pc_reg       <= redirect_pc;
            inflight_reg <= 1'b0;
            halted_reg   <= 1'b0;
        end else begin
            inflight_reg <= issue;
            if (issue) begin
                pc_reg       <= pc_reg + AW'(1);
                req_addr_reg <= pc_reg;
            end
            if (do_push && is_hlt(imem_rdata)) begin
                halted_reg <= 1'b1;
            end
        end
    end

    mips_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk1  (clk1),
        .rst   (rst),
        .push  (do_push),
        .pop   (do_pop),
        .flush (redirect_valid),
        .din   (push_entry),
        .count (count),
        .head  (head_entry)
    );

    assign id_npc    = head_entry[EW-1 -: AW];
    assign id_instr  = head_entry[INSTR_W-1:0];
    assign halted    = halted_reg;
    assign occupancy = count;

endmodule
